// File: rtl/latch_input_conditioner.sv
// Pad-side conditioner for the D-latch datapath: two-flop sync, per-channel
// debounce, registered edge strobes and a saturating glitch-reject counter.

module latch_input_conditioner_chan #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic lvl,
  output logic take,
  output logic glitch
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // take: mismatch has persisted long enough, lvl flips on this edge
  assign take   = ena && (s2 != lvl) && (cnt == LAST);
  assign glitch = ena && (s2 == lvl) && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      lvl <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (ena) begin
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (take) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module latch_input_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int GLITCH_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                raw_d,
  input  logic                raw_e,
  output logic                d_out,
  output logic                e_out,
  output logic                e_rise,
  output logic                e_fall,
  output logic                d_chg,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam logic [GLITCH_W+1:0] GMAX = {2'b00, {GLITCH_W{1'b1}}};

  // channel 0 = D, channel 1 = E
  logic [1:0] raw, lvl, take, glitch;
  logic [GLITCH_W+1:0] gsum;

  assign raw = {raw_e, raw_d};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    latch_input_conditioner_chan #(.DEB_CYCLES(DEB_CYCLES)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .raw    (raw[c]),
      .lvl    (lvl[c]),
      .take   (take[c]),
      .glitch (glitch[c])
    );
  end

  assign d_out = lvl[0];
  assign e_out = lvl[1];

  // two extra headroom bits so a double increment near the top is caught
  assign gsum = {2'b00, glitch_cnt} + (GLITCH_W+2)'(glitch[0])
                                    + (GLITCH_W+2)'(glitch[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_chg      <= 1'b0;
      e_rise     <= 1'b0;
      e_fall     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      d_chg  <= take[0];
      e_rise <= take[1] & ~lvl[1];
      e_fall <= take[1] &  lvl[1];
      if (gsum > GMAX) glitch_cnt <= '1;
      else             glitch_cnt <= gsum[GLITCH_W-1:0];
    end
  end
endmodule

// File: doc/latch_input_conditioner.md
Name: latch_input_conditioner

Overview:
- Upstream front-end for the D-latch datapath. Takes the raw asynchronous pad inputs for data (D) and enable (E) and produces clean, synchronised, debounced D/E levels that feed the latch stage.
- Also produces single-cycle edge strobes and a saturating glitch-reject counter for observability on spare outputs.
- Everything sits in one clock domain (clk).

Parameters:
- DEB_CYCLES, default 4: consecutive synchronised cycles a new level must persist before the output accepts it. Legal range is 1..255.
- GLITCH_W, default 8: width of the glitch-reject counter.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- ena, input, 1: advance enable; when low, debounce state holds.
- raw_d, input, 1: asynchronous data input from the pad.
- raw_e, input, 1: asynchronous latch-enable input from the pad.
- d_out, output, 1: debounced, synchronised D level, to the latch.
- e_out, output, 1: debounced, synchronised E level, to the latch.
- e_rise, output, 1: one-cycle strobe; e_out went 0->1 this cycle.
- e_fall, output, 1: one-cycle strobe; e_out went 1->0 this cycle.
- d_chg, output, 1: one-cycle strobe; d_out changed this cycle.
- glitch_cnt, output, GLITCH_W: count of rejected pulses on either channel; saturates.

Behaviour:
- Reset (rst_n low at a rising edge) clears all state to zero:
  - sync flops, debounce counters, d_out, e_out, e_rise, e_fall, d_chg, glitch_cnt = 0.
  - Reset mid-debounce discards the partial count.
- Synchroniser, per channel:
  - Two-flop chain s1 <= raw, s2 <= s1.
  - Runs every cycle regardless of ena; only reset clears it.
- Debounce, per channel (identical, independent):
  - Counter width is clog2(DEB_CYCLES+1).
  - If s2 == out: counter <= 0.
  - If s2 != out and counter == DEB_CYCLES-1: out <= s2 and counter <= 0.
  - If s2 != out otherwise: counter <= counter+1.
- Latency:
  - A raw level first sampled into s1 at edge k, and held, appears on the output at edge k+1+DEB_CYCLES.
  - DEB_CYCLES=4 gives a flip at edge k+5; DEB_CYCLES=1 gives a flip at edge k+2.
- Glitch reject:
  - A glitch is a cycle where counter != 0 and s2 == out, i.e. the mismatch ended before acceptance.
  - Such a cycle increments glitch_cnt by 1 per channel event.
  - If both channels glitch in the same cycle, glitch_cnt adds 2.
  - glitch_cnt saturates at all-ones and never wraps.
- Strobes:
  - Registered on the same edge that updates the corresponding output, so each strobe is high exactly during the first cycle the new level is visible.
  - Otherwise 0.
  - e_rise and e_fall are mutually exclusive.
  - D and E may flip in the same cycle; d_chg and e_rise/e_fall then assert together.
- ena low:
  - Debounce counters, outputs and glitch_cnt hold.
  - Strobes are forced to 0.
  - Synchroniser continues to run.
  - On ena returning high, evaluation resumes with the held counter values.
- Outputs are glitch-free register outputs; no combinational path from raw_* to any output.

Test Plan:
- Reset: drive raw_d=1, raw_e=1 with rst_n=0 for 3 cycles, then release -> all outputs 0 during reset. With DEB_CYCLES=4, d_out and e_out rise 5 edges after the first post-reset sampling edge. e_rise and d_chg are high for exactly 1 cycle; glitch_cnt=0.
- Latency sweep: DEB_CYCLES in {1,4,255}; step raw_e 0->1 and hold -> e_out rises exactly 2/5/256 edges after the sampling edge. e_rise is a single cycle; e_fall never asserts.
- Glitch reject: DEB_CYCLES=4; raw_d high for 3 cycles then low -> d_out stays 0, d_chg stays 0, glitch_cnt=1. Repeat 300 times with GLITCH_W=8 -> glitch_cnt holds at 255.
- Simultaneous: raw_d and raw_e both 0->1 on the same edge -> d_out and e_out flip on the same cycle, with d_chg and e_rise asserted together. Same-cycle glitches on both channels -> glitch_cnt += 2.
- ena hold: start an E transition, drop ena after 2 counted cycles for 10 cycles, then raise it -> e_out flips only after 2 further counted cycles. No strobes while ena=0.
- Reset mid-debounce: assert rst_n=0 one cycle before acceptance -> e_out=0 and the counter clears. Re-release with raw_e held high -> full DEB_CYCLES+1 edge latency from the first post-reset sample.
